// File: rtl/obi_wb_arbiter.sv
// Round-robin arbiter that shares one Wishbone classic master between the OBI
// instruction and data ports, with a watchdog that aborts unacknowledged cycles.
module obi_wb_arbiter #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    instr_req_i,
    output logic                    instr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic                    instr_err_o,

    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_err_o,

    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i
);

    localparam bit              WD_EN   = (TIMEOUT_CYCLES > 0);
    localparam int unsigned     WD_W    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic { IDLE, BUSY } state_e;
    typedef enum logic { PORT_INSTR, PORT_DATA } port_e;

    state_e          state;
    port_e           owner;
    port_e           last_grant;
    logic [WD_W-1:0] wd_cnt;

    logic grant_instr;
    logic grant_data;
    logic timeout;

    // On a tie, the port that did not win last time gets the bus.
    always_comb begin
        grant_instr = 1'b0;
        grant_data  = 1'b0;
        if (state == IDLE) begin
            if (instr_req_i && data_req_i) begin
                grant_instr = (last_grant == PORT_DATA);
                grant_data  = (last_grant == PORT_INSTR);
            end else begin
                grant_instr = instr_req_i;
                grant_data  = data_req_i;
            end
        end
    end

    assign instr_gnt_o = grant_instr;
    assign data_gnt_o  = grant_data;
    assign wb_stb_o    = wb_cyc_o;

    // An ack on the final watchdog cycle wins over the abort.
    assign timeout = WD_EN && (wd_cnt == WD_LAST) && !wb_ack_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            owner          <= PORT_INSTR;
            last_grant     <= PORT_DATA;
            wd_cnt         <= '0;
            wb_cyc_o       <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_sel_o       <= '0;
            wb_adr_o       <= '0;
            wb_dat_o       <= '0;
            instr_rvalid_o <= 1'b0;
            instr_rdata_o  <= '0;
            instr_err_o    <= 1'b0;
            data_rvalid_o  <= 1'b0;
            data_rdata_o   <= '0;
            data_err_o     <= 1'b0;
        end else begin
            instr_rvalid_o <= 1'b0;
            data_rvalid_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_instr || grant_data) begin
                        state    <= BUSY;
                        wb_cyc_o <= 1'b1;
                        wd_cnt   <= '0;
                        if (grant_instr) begin
                            owner      <= PORT_INSTR;
                            last_grant <= PORT_INSTR;
                            wb_we_o    <= 1'b0;
                            wb_sel_o   <= '1;
                            wb_adr_o   <= instr_addr_i;
                            wb_dat_o   <= '0;
                        end else begin
                            owner      <= PORT_DATA;
                            last_grant <= PORT_DATA;
                            wb_we_o    <= data_we_i;
                            wb_sel_o   <= data_be_i;
                            wb_adr_o   <= data_addr_i;
                            wb_dat_o   <= data_wdata_i;
                        end
                    end
                end
                BUSY: begin
                    if (wb_ack_i || timeout) begin
                        state    <= IDLE;
                        wb_cyc_o <= 1'b0;
                        if (owner == PORT_INSTR) begin
                            instr_rvalid_o <= 1'b1;
                            instr_rdata_o  <= wb_ack_i ? wb_dat_i : ERR_DATA;
                            instr_err_o    <= !wb_ack_i;
                        end else begin
                            data_rvalid_o  <= 1'b1;
                            data_rdata_o   <= wb_ack_i ? wb_dat_i : ERR_DATA;
                            data_err_o     <= !wb_ack_i;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obi_wb_arbiter.sv
// Directed bench for obi_wb_arbiter: single transfers, round-robin ties,
// wait states, watchdog abort and mid-transaction reset.
module tb_obi_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        instr_req_i;
    logic        instr_gnt_o;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int n_checks = 0;
    int n_fails  = 0;

    obi_wb_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_we_o        (wb_we_o),
        .wb_sel_o       (wb_sel_o),
        .wb_adr_o       (wb_adr_o),
        .wb_dat_o       (wb_dat_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = '0;
        data_addr_i  = '0;
        data_wdata_i = '0;
        wb_dat_i     = '0;
        wb_ack_i     = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_cyc",     wb_cyc_o,       0);
        check("rst_stb",     wb_stb_o,       0);
        check("rst_adr",     wb_adr_o,       0);
        check("rst_sel",     wb_sel_o,       0);
        check("rst_irvalid", instr_rvalid_o, 0);
        check("rst_drvalid", data_rvalid_o,  0);
        check("rst_irdata",  instr_rdata_o,  0);
        check("rst_derr",    data_err_o,     0);
        rst_n = 1'b1;
        tick();

        // Single instruction read, zero-wait slave
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h100;
        #1;
        check("t1_ignt", instr_gnt_o, 1);
        check("t1_dgnt", data_gnt_o,  0);
        tick();
        instr_req_i = 1'b0;
        check("t1_cyc", wb_cyc_o, 1);
        check("t1_stb", wb_stb_o, 1);
        check("t1_adr", wb_adr_o, 32'h100);
        check("t1_sel", wb_sel_o, 4'hF);
        check("t1_we",  wb_we_o,  0);
        check("t1_dat", wb_dat_o, 0);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_0013;
        tick();
        wb_ack_i = 1'b0;
        check("t1_irvalid", instr_rvalid_o, 1);
        check("t1_irdata",  instr_rdata_o,  32'h13);
        check("t1_ierr",    instr_err_o,    0);
        check("t1_drvalid", data_rvalid_o,  0);
        check("t1_cyc_end", wb_cyc_o,       0);
        tick();
        check("t1_irvalid_pulse", instr_rvalid_o, 0);

        // Data byte write
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'h2;
        data_addr_i  = 32'h2004;
        data_wdata_i = 32'h0000_AB00;
        #1;
        check("t2_dgnt", data_gnt_o,  1);
        check("t2_ignt", instr_gnt_o, 0);
        tick();
        data_req_i = 1'b0;
        check("t2_we",  wb_we_o,  1);
        check("t2_sel", wb_sel_o, 4'h2);
        check("t2_adr", wb_adr_o, 32'h2004);
        check("t2_dat", wb_dat_o, 32'h0000_AB00);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h5555_0000;
        tick();
        wb_ack_i  = 1'b0;
        data_we_i = 1'b0;
        check("t2_drvalid", data_rvalid_o,  1);
        check("t2_derr",    data_err_o,     0);
        check("t2_irvalid", instr_rvalid_o, 0);
        tick();
        check("t2_drvalid_pulse", data_rvalid_o, 0);

        // Contention: last grant was data, so instr, data, instr, data
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h300;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h400;
        data_be_i    = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t3_ignt%0d", i), instr_gnt_o, (i % 2 == 0) ? 1 : 0);
            check($sformatf("t3_dgnt%0d", i), data_gnt_o,  (i % 2 == 0) ? 0 : 1);
            tick();
            check($sformatf("t3_busy_gnt%0d", i), {instr_gnt_o, data_gnt_o}, 0);
            check($sformatf("t3_adr%0d", i), wb_adr_o, (i % 2 == 0) ? 32'h300 : 32'h400);
            wb_ack_i = 1'b1;
            wb_dat_i = 32'hA0 + i;
            tick();
            wb_ack_i = 1'b0;
            check($sformatf("t3_irv%0d", i), instr_rvalid_o, (i % 2 == 0) ? 1 : 0);
            check($sformatf("t3_drv%0d", i), data_rvalid_o,  (i % 2 == 0) ? 0 : 1);
        end
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        tick();

        // Wait states: ack on the 5th BUSY cycle, data requests during BUSY ignored
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h500;
        #1;
        check("t4_ignt", instr_gnt_o, 1);
        tick();
        instr_req_i = 1'b0;
        data_req_i  = 1'b1;
        data_addr_i = 32'h600;
        wb_dat_i    = 32'hCAFE_0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t4_cyc%0d", k), wb_cyc_o, 1);
            check($sformatf("t4_adr%0d", k), wb_adr_o, 32'h500);
            check($sformatf("t4_sel%0d", k), wb_sel_o, 4'hF);
            check($sformatf("t4_gnt%0d", k), {instr_gnt_o, data_gnt_o}, 0);
            check($sformatf("t4_rv%0d",  k), instr_rvalid_o, 0);
            if (k == 4) begin
                wb_ack_i   = 1'b1;
                data_req_i = 1'b0;
            end
            tick();
        end
        wb_ack_i = 1'b0;
        check("t4_irvalid", instr_rvalid_o, 1);
        check("t4_irdata",  instr_rdata_o,  32'hCAFE_0001);
        check("t4_cyc_end", wb_cyc_o,       0);
        tick();
        check("t4_irvalid_pulse", instr_rvalid_o, 0);

        // Watchdog: data read never acked, aborted after 8 BUSY cycles
        data_req_i  = 1'b1;
        data_addr_i = 32'h700;
        #1;
        check("t5_dgnt", data_gnt_o, 1);
        tick();
        data_req_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t5_cyc%0d", k), wb_cyc_o, 1);
            check($sformatf("t5_rv%0d",  k), data_rvalid_o, 0);
            tick();
        end
        check("t5_cyc_end", wb_cyc_o,      0);
        check("t5_drvalid", data_rvalid_o, 1);
        check("t5_derr",    data_err_o,    1);
        check("t5_drdata",  data_rdata_o,  32'hDEAD_BEEF);
        tick();
        check("t5_derr_hold", data_err_o, 1);

        // Next request after the abort proceeds normally
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h800;
        #1;
        check("t5b_ignt", instr_gnt_o, 1);
        tick();
        instr_req_i = 1'b0;
        check("t5b_adr", wb_adr_o, 32'h800);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h1234;
        tick();
        wb_ack_i = 1'b0;
        check("t5b_irvalid", instr_rvalid_o, 1);
        check("t5b_ierr",    instr_err_o,    0);
        check("t5b_irdata",  instr_rdata_o,  32'h1234);
        tick();

        // Ack on the final watchdog cycle completes normally
        data_req_i  = 1'b1;
        data_addr_i = 32'h900;
        #1;
        check("t6_dgnt", data_gnt_o, 1);
        tick();
        data_req_i = 1'b0;
        repeat (7) tick();
        check("t6_cyc_last", wb_cyc_o, 1);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0BAD_F00D;
        tick();
        wb_ack_i = 1'b0;
        check("t6_drvalid", data_rvalid_o, 1);
        check("t6_derr",    data_err_o,    0);
        check("t6_drdata",  data_rdata_o,  32'h0BAD_F00D);
        tick();

        // Reset during BUSY after an instr grant
        instr_req_i  = 1'b1;
        instr_addr_i = 32'hA00;
        #1;
        check("t7_ignt", instr_gnt_o, 1);
        tick();
        instr_req_i = 1'b0;
        check("t7_cyc", wb_cyc_o, 1);
        rst_n = 1'b0;
        #1;
        check("t7_cyc_rst", wb_cyc_o, 0);
        check("t7_adr_rst", wb_adr_o, 0);
        tick();
        check("t7_irvalid", instr_rvalid_o, 0);
        check("t7_drvalid", data_rvalid_o,  0);
        rst_n = 1'b1;
        tick();
        check("t7_no_late_rv", instr_rvalid_o, 0);
        instr_req_i = 1'b1;
        data_req_i  = 1'b1;
        #1;
        check("t7_tie_ignt", instr_gnt_o, 1);
        check("t7_tie_dgnt", data_gnt_o,  0);
        tick();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        check("t7_adr", wb_adr_o, 32'hA00);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("t7_irvalid_end", instr_rvalid_o, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
